// File: rtl/gray_pkg.sv
// Shared grayscale pixel definitions and the 2-input floor average.
package gray_pkg;

  localparam int unsigned PIXEL_W = 8;
  localparam int unsigned SUM_W   = PIXEL_W + 1;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Floor of the mean of two pixels; the extra sum bit keeps 255+255 exact.
  function automatic pixel_t avg_floor(input pixel_t a, input pixel_t b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return sum[SUM_W-1:1];
  endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// Single-row pixel store: one write port, one read port with registered output.
module gray_line_buffer
  import gray_pkg::*;
#(
  parameter int unsigned DEPTH  = 960,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [DEPTH];
  pixel_t rd_data_q;

  // RAM array write and synchronous read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gray_vert_downsample.sv
// 2:1 vertical downsampler: buffers even rows, averages each odd-row pixel
// with the same-column even-row pixel, one output row per input row pair.
module gray_vert_downsample
  import gray_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 960
) (
  input  logic   clk,
  input  logic   reset,
  input  pixel_t pixel_in,
  input  logic   pixel_in_valid,
  input  logic   pixel_in_sof,
  output pixel_t pixel_out,
  output logic   pixel_out_valid,
  output logic   pixel_out_eol
);

  localparam int unsigned ADDR_W = $clog2(LINE_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic              row_odd_q, row_odd_d;
  logic              v1_q, v1_d;
  logic              eol1_q, eol1_d;
  pixel_t            pix1_q, pix1_d;
  logic              out_valid_q, out_valid_d;
  logic              out_eol_q, out_eol_d;
  pixel_t            pixel_out_q, pixel_out_d;

  logic [ADDR_W-1:0] cur_col_c;
  logic              cur_odd_c;
  logic              last_col_c;
  logic              wr_en_c;
  logic              rd_en_c;
  pixel_t            rd_data;

  gray_line_buffer #(
    .DEPTH  (LINE_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (cur_col_c),
    .wr_data (pixel_in),
    .rd_en   (rd_en_c),
    .rd_addr (cur_col_c),
    .rd_data (rd_data)
  );

  // Position of the current pixel (sof overrides counters), next counters, pipeline inputs.
  always_comb begin
    cur_col_c  = pixel_in_sof ? '0 : col_q;
    cur_odd_c  = pixel_in_sof ? 1'b0 : row_odd_q;
    last_col_c = (cur_col_c == LAST_COL);
    col_d      = col_q;
    row_odd_d  = row_odd_q;
    wr_en_c    = pixel_in_valid & ~cur_odd_c;
    rd_en_c    = pixel_in_valid &  cur_odd_c;

    if (pixel_in_valid) begin
      if (last_col_c) begin
        col_d     = '0;
        row_odd_d = ~cur_odd_c;
      end else begin
        col_d     = cur_col_c + ADDR_W'(1);
        row_odd_d = cur_odd_c;
      end
    end

    v1_d        = rd_en_c;
    eol1_d      = rd_en_c & last_col_c;
    pix1_d      = pixel_in;
    out_valid_d = v1_q;
    out_eol_d   = eol1_q;
    pixel_out_d = v1_q ? avg_floor(rd_data, pix1_q) : pixel_out_q;
  end

  // Control state: counters and pipeline valids, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_odd_q   <= 1'b0;
      v1_q        <= 1'b0;
      eol1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_odd_q   <= row_odd_d;
      v1_q        <= v1_d;
      eol1_q      <= eol1_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Pixel datapath registers; output holds its last value through reset.
  always_ff @(posedge clk) begin
    pix1_q      <= pix1_d;
    pixel_out_q <= pixel_out_d;
  end

  assign pixel_out       = pixel_out_q;
  assign pixel_out_valid = out_valid_q;
  assign pixel_out_eol   = out_eol_q;

endmodule

// File: tb/tb_gray_vert_downsample.sv
// Randomized and directed bench for gray_vert_downsample against a row-list model.
module tb_gray_vert_downsample;

  localparam int unsigned LW = 4;

  typedef struct packed {
    logic       v;
    logic       eol;
    logic [7:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic       pixel_in_sof;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;
  logic       pixel_out_eol;

  int   n_vec = 0;
  int   n_bad = 0;

  int   even_row [LW];
  int   cur_row  [$];
  bit   odd;
  exp_t pq       [$];
  int   obs      [$];

  gray_vert_downsample #(.LINE_WIDTH(LW)) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_in_sof    (pixel_in_sof),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .pixel_out_eol   (pixel_out_eol)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs_v, input int exp_v);
    n_vec++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs_v, exp_v, $time);
    end
  endtask

  // Reference: pixels are collected into the current row; a complete even row
  // becomes the stored row, every odd-row pixel yields floor((even+odd)/2).
  task automatic model(input bit v, input bit s, input int p, output exp_t e);
    int idx;
    e = '0;
    if (!v) return;
    if (s) begin
      cur_row.delete();
      odd = 1'b0;
    end
    idx = cur_row.size();
    cur_row.push_back(p);
    if (odd) begin
      e.v   = 1'b1;
      e.p   = 8'((even_row[idx] + p) / 2);
      e.eol = (idx == LW - 1);
    end
    if (cur_row.size() == LW) begin
      if (!odd) for (int i = 0; i < LW; i++) even_row[i] = cur_row[i];
      odd = ~odd;
      cur_row.delete();
    end
  endtask

  task automatic step(input bit v, input bit s, input int p);
    exp_t e;
    exp_t o;
    @(negedge clk);
    reset          = 1'b0;
    pixel_in_valid = v;
    pixel_in_sof   = s;
    pixel_in       = 8'(p);
    model(v, s, p, e);
    @(posedge clk);
    #1;
    pq.push_back(e);
    if (pq.size() == 2) begin
      o = pq.pop_front();
      check("out_valid", int'(pixel_out_valid), int'(o.v));
      check("out_eol", int'(pixel_out_eol), int'(o.eol));
      if (o.v) check("out_pixel", int'(pixel_out), int'(o.p));
    end
    if (pixel_out_valid) obs.push_back(int'(pixel_out));
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    reset          = 1'b1;
    pixel_in_valid = 1'b0;
    pixel_in_sof   = 1'b0;
    pixel_in       = 8'h00;
    @(posedge clk);
    #1;
    cur_row.delete();
    odd = 1'b0;
    pq.delete();
    z = '0;
    pq.push_back(z);
    check("rst_valid", int'(pixel_out_valid), 0);
    check("rst_eol", int'(pixel_out_eol), 0);
  endtask

  task automatic send_row(input int a, input int b, input int c, input int d, input bit first_sof);
    step(1'b1, first_sof, a);
    step(1'b1, 1'b0, b);
    step(1'b1, 1'b0, c);
    step(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    int exp1 [4];
    int pat  [7];
    int k;
    reset          = 1'b1;
    pixel_in_valid = 1'b0;
    pixel_in_sof   = 1'b0;
    pixel_in       = 8'h00;
    do_reset();
    do_reset();

    // 1: basic contiguous row pair
    obs.delete();
    send_row(10, 20, 30, 40, 1'b1);
    send_row(30, 40, 50, 60, 1'b0);
    idle(2);
    exp1 = '{20, 30, 40, 50};
    check("t1_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) check("t1_val", obs[i], exp1[i]);

    // 2: saturation and floor
    obs.delete();
    send_row(255, 255, 255, 255, 1'b1);
    send_row(255, 255, 255, 255, 1'b0);
    idle(2);
    check("t2_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) check("t2_max", obs[i], 255);
    obs.delete();
    send_row(0, 1, 0, 1, 1'b1);
    send_row(1, 0, 0, 1, 1'b0);
    idle(2);
    exp1 = '{0, 0, 0, 1};
    check("t2f_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) check("t2_floor", obs[i], exp1[i]);

    // 3: odd row with bubbles
    send_row(7, 9, 100, 201, 1'b1);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      step(pat[i] != 0, 1'b0, 50 + 13 * i);
    end
    idle(2);

    // 4: four rows back-to-back
    obs.delete();
    send_row(1, 2, 3, 4, 1'b1);
    send_row(5, 6, 7, 8, 1'b0);
    send_row(100, 110, 120, 130, 1'b0);
    send_row(200, 210, 220, 230, 1'b0);
    idle(2);
    check("t4_count", obs.size(), 8);

    // 5: mid-row sof in odd row
    obs.delete();
    send_row(11, 22, 33, 44, 1'b1);
    step(1'b1, 1'b0, 55);
    step(1'b1, 1'b0, 66);
    send_row(80, 90, 100, 110, 1'b1);
    send_row(2, 4, 6, 8, 1'b0);
    idle(2);
    check("t5_count", obs.size(), 6);

    // 6: reset after two odd-row inputs
    send_row(40, 50, 60, 70, 1'b1);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 2);
    do_reset();
    obs.delete();
    send_row(9, 19, 29, 39, 1'b0);
    send_row(3, 5, 7, 9, 1'b0);
    idle(2);
    check("t6_count", obs.size(), 4);

    // Random traffic with occasional sof and reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, int'($urandom_range(0, 255)));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
